// File: rtl/rv_alu2_pkg.sv
// Shared types and constants for the second execute stage and its divider.
package rv_alu2_pkg;

    localparam int RES_SRC_BITS = 2;

    // ALU modifiers: SUB/SRA select and divide request
    typedef struct packed {
        logic sub_sra;
        logic div;
    } alu_ctrl_t;

    // One-hot result select; 'logic' is reserved, so that field is 'logical'
    typedef struct packed {
        logic arith;
        logic shift;
        logic logical;
        logic cmp;
        logic link;
        logic div;
    } alu_res_t;

    // Integer op funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch compare funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Divide funct3: bit 1 picks remainder, bit 0 picks unsigned
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    function automatic logic [31:0] negateIf(input logic neg, input logic [31:0] value);
        return neg ? -value : value;
    endfunction

endpackage

// File: rtl/rv_alu2_div.sv
// Iterative radix-2 restoring divider working on magnitudes, with sign
// fix-up on the way out. Divide-by-zero and signed overflow bypass the loop.
module rv_div
    import rv_alu2_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_ack,
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    div_state_t  r_state;
    div_state_t  w_nextState;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic [4:0]  r_count;
    logic        r_negQuot;
    logic        r_negRem;
    logic        w_divByZero;
    logic        w_overflow;
    logic        w_special;
    logic        w_load;
    logic [32:0] w_shifted;
    logic [32:0] w_diff;

    assign w_divByZero = (i_divisor == 32'd0);
    assign w_overflow  = i_signed && (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF);
    assign w_special   = w_divByZero || w_overflow;
    assign w_load      = (r_state == DIV_IDLE) && i_start && !w_special;
    assign w_shifted   = {r_rem, r_quot[31]};
    assign w_diff      = w_shifted - {1'b0, r_divisor};

    assign o_busy = (r_state == DIV_RUN) || w_load;

    // State register; abort wins over everything else
    always_ff @(posedge i_clk) begin
        if (i_reset || i_abort) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: load, 32 steps, then hold the answer until it is taken
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            DIV_IDLE: if (w_load) w_nextState = DIV_RUN;
            DIV_RUN:  if (r_count == 5'd0) w_nextState = DIV_DONE;
            DIV_DONE: if (i_ack) w_nextState = DIV_IDLE;
            default:  w_nextState = DIV_IDLE;
        endcase
    end

    // Datapath: capture magnitudes on load, one restoring step per RUN cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
        end else if (w_load) begin
            r_quot    <= negateIf(i_signed && i_dividend[31], i_dividend);
            r_rem     <= '0;
            r_divisor <= negateIf(i_signed && i_divisor[31], i_divisor);
            r_count   <= 5'd31;
            r_negQuot <= i_signed && (i_dividend[31] ^ i_divisor[31]);
            r_negRem  <= i_signed && i_dividend[31];
        end else if (r_state == DIV_RUN) begin
            if (!w_diff[32]) begin
                r_rem  <= w_diff[31:0];
                r_quot <= {r_quot[30:0], 1'b1};
            end else begin
                r_rem  <= w_shifted[31:0];
                r_quot <= {r_quot[30:0], 1'b0};
            end
            r_count <= r_count - 5'd1;
        end
    end

    // Result: finished loop value, otherwise the special-case answer
    always_comb begin
        o_quotient  = 32'hFFFF_FFFF;
        o_remainder = i_dividend;
        if (r_state == DIV_DONE) begin
            o_quotient  = negateIf(r_negQuot, r_quot);
            o_remainder = negateIf(r_negRem, r_rem);
        end else if (w_overflow) begin
            o_quotient  = 32'h8000_0000;
            o_remainder = 32'd0;
        end
    end

endmodule

// File: rtl/rv_alu2.sv
// Second execute stage: integer result, branch/jump resolution against the
// fetch prediction, iterative divide, and the registers feeding the memory stage.
module rv_alu2
    import rv_alu2_pkg::*;
#(
    parameter int IADDR_SPACE_BITS = 32
)
(
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_flush,
    input  logic                        i_stall,
    input  logic [31:0]                 i_op1,
    input  logic [31:0]                 i_op2,
    input  alu_res_t                    i_res,
    input  alu_ctrl_t                   i_alu_ctrl,
    input  logic [2:0]                  i_funct3,
    input  logic [RES_SRC_BITS-1:0]     i_res_src,
    input  logic                        i_reg_write,
    input  logic [4:0]                  i_rd,
    input  logic                        i_store,
    input  logic                        i_to_trap,
    input  logic [31:0]                 i_reg_data2,
    input  logic                        i_inst_jal_jalr,
    input  logic                        i_inst_branch,
    input  logic                        i_branch_pred,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
    output logic                        o_busy,
    output logic [31:0]                 o_result,
    output logic [31:0]                 o_store_data,
    output logic [4:0]                  o_rd,
    output logic                        o_reg_write,
    output logic                        o_store,
    output logic                        o_to_trap,
    output logic [RES_SRC_BITS-1:0]     o_res_src,
    output logic [2:0]                  o_funct3,
    output logic                        o_pc_change,
    output logic [IADDR_SPACE_BITS-1:0] o_pc_new
);

    logic                        w_divBusy;
    logic                        w_capture;
    logic [31:0]                 w_quot;
    logic [31:0]                 w_rem;
    logic [4:0]                  w_shamt;
    logic [31:0]                 w_sra;
    logic                        w_eq;
    logic                        w_lt;
    logic                        w_ltu;
    logic                        w_taken;
    logic [31:0]                 w_result;
    logic                        w_pcChange;
    logic [IADDR_SPACE_BITS-1:0] w_pcNew;
    logic                        w_unusedPc;

    logic [31:0]                 r_result;
    logic [31:0]                 r_storeData;
    logic [4:0]                  r_rd;
    logic                        r_regWrite;
    logic                        r_store;
    logic                        r_toTrap;
    logic [RES_SRC_BITS-1:0]     r_resSrc;
    logic [2:0]                  r_funct3;
    logic                        r_pcChange;
    logic [IADDR_SPACE_BITS-1:0] r_pcNew;

    // The instruction's own PC plays no part in this stage
    assign w_unusedPc = ^i_pc;

    // Divisor arrives on op1 and dividend on op2
    rv_div u_div (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_alu_ctrl.div),
        .i_abort     (i_flush),
        .i_ack       (w_capture),
        .i_signed    (!i_funct3[0]),
        .i_dividend  (i_op2),
        .i_divisor   (i_op1),
        .o_busy      (w_divBusy),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    assign o_busy    = w_divBusy;
    assign w_capture = !i_stall && !w_divBusy;
    assign w_shamt   = i_op2[4:0];
    assign w_sra     = $signed(i_op1) >>> w_shamt;
    assign w_eq      = (i_op1 == i_op2);
    assign w_lt      = ($signed(i_op1) < $signed(i_op2));
    assign w_ltu     = (i_op1 < i_op2);

    // Integer result picked by the one-hot result select
    always_comb begin
        w_result = '0;
        if (i_res.arith) begin
            w_result = i_alu_ctrl.sub_sra ? (i_op1 - i_op2) : (i_op1 + i_op2);
        end else if (i_res.shift) begin
            case (i_funct3)
                F3_SLL:  w_result = i_op1 << w_shamt;
                F3_SR:   w_result = i_alu_ctrl.sub_sra ? w_sra : (i_op1 >> w_shamt);
                default: w_result = '0;
            endcase
        end else if (i_res.logical) begin
            case (i_funct3)
                F3_XOR:  w_result = i_op1 ^ i_op2;
                F3_OR:   w_result = i_op1 | i_op2;
                F3_AND:  w_result = i_op1 & i_op2;
                default: w_result = '0;
            endcase
        end else if (i_res.cmp) begin
            w_result = {31'd0, (i_funct3 == F3_SLTU) ? w_ltu : w_lt};
        end else if (i_res.link) begin
            w_result = 32'(i_pc_next);
        end else if (i_res.div) begin
            w_result = i_funct3[1] ? w_rem : w_quot;
        end
    end

    // Branch condition for the compare variant in funct3
    always_comb begin
        case (i_funct3)
            F3_BEQ:  w_taken = w_eq;
            F3_BNE:  w_taken = !w_eq;
            F3_BLT:  w_taken = w_lt;
            F3_BGE:  w_taken = !w_lt;
            F3_BLTU: w_taken = w_ltu;
            F3_BGEU: w_taken = !w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // Redirect only when the real outcome disagrees with fetch's guess
    always_comb begin
        w_pcChange = 1'b0;
        w_pcNew    = i_pc_target;
        if (i_inst_jal_jalr) begin
            w_pcChange = 1'b1;
        end else if (i_inst_branch) begin
            if (w_taken && !i_branch_pred) begin
                w_pcChange = 1'b1;
            end else if (!w_taken && i_branch_pred) begin
                w_pcChange = 1'b1;
                w_pcNew    = i_pc_next;
            end
        end
    end

    // Output registers: clear on reset/flush, load when free, bubble while dividing
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_result    <= '0;
            r_storeData <= '0;
            r_rd        <= '0;
            r_regWrite  <= 1'b0;
            r_store     <= 1'b0;
            r_toTrap    <= 1'b0;
            r_resSrc    <= '0;
            r_funct3    <= '0;
            r_pcChange  <= 1'b0;
            r_pcNew     <= '0;
        end else if (w_capture) begin
            r_result    <= w_result;
            r_storeData <= i_reg_data2;
            r_rd        <= i_rd;
            r_regWrite  <= i_reg_write;
            r_store     <= i_store;
            r_toTrap    <= i_to_trap;
            r_resSrc    <= i_res_src;
            r_funct3    <= i_funct3;
            r_pcChange  <= w_pcChange;
            r_pcNew     <= w_pcNew;
        end else if (!i_stall) begin
            r_regWrite  <= 1'b0;
            r_store     <= 1'b0;
            r_toTrap    <= 1'b0;
            r_pcChange  <= 1'b0;
        end
    end

    assign o_result     = r_result;
    assign o_store_data = r_storeData;
    assign o_rd         = r_rd;
    assign o_reg_write  = r_regWrite;
    assign o_store      = r_store;
    assign o_to_trap    = r_toTrap;
    assign o_res_src    = r_resSrc;
    assign o_funct3     = r_funct3;
    assign o_pc_change  = r_pcChange;
    assign o_pc_new     = r_pcNew;

endmodule

// File: tb/tb_rv_alu2.sv
// Scoreboard bench for rv_alu2: directed vectors push hand-computed results,
// a monitor pops them whenever a new register-writing output appears.
module tb_rv_alu2;
    import rv_alu2_pkg::*;

    localparam logic [31:0] PC_CUR    = 32'h0000_0100;
    localparam logic [31:0] PC_NEXT   = 32'h0000_0104;
    localparam logic [31:0] PC_TARGET = 32'h0000_0200;

    localparam alu_res_t RES_NONE  = 6'b000000;
    localparam alu_res_t RES_ARITH = 6'b100000;
    localparam alu_res_t RES_SHIFT = 6'b010000;
    localparam alu_res_t RES_LOGIC = 6'b001000;
    localparam alu_res_t RES_CMP   = 6'b000100;
    localparam alu_res_t RES_LINK  = 6'b000010;
    localparam alu_res_t RES_DIV   = 6'b000001;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        pcChange;
        logic [31:0] pcNew;
        logic [31:0] storeData;
        logic [4:0]  rd;
        int          dueCycle;
    } expect_t;

    logic        clk = 1'b0;
    logic        i_reset, i_flush, i_stall;
    logic [31:0] i_op1, i_op2, i_reg_data2;
    alu_res_t    i_res;
    alu_ctrl_t   i_alu_ctrl;
    logic [2:0]  i_funct3;
    logic [1:0]  i_res_src;
    logic        i_reg_write, i_store, i_to_trap;
    logic [4:0]  i_rd;
    logic        i_inst_jal_jalr, i_inst_branch, i_branch_pred;
    logic [31:0] i_pc, i_pc_next, i_pc_target;
    logic        o_busy, o_reg_write, o_store, o_to_trap, o_pc_change;
    logic [31:0] o_result, o_store_data, o_pc_new;
    logic [4:0]  o_rd;
    logic [1:0]  o_res_src;
    logic [2:0]  o_funct3;

    int      cycle = 0;
    int      checkCount = 0;
    int      missCount = 0;
    int      tag = 0;
    expect_t sbQueue[$];

    rv_alu2 #(.IADDR_SPACE_BITS(32)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_stall(i_stall),
        .i_op1(i_op1), .i_op2(i_op2), .i_res(i_res), .i_alu_ctrl(i_alu_ctrl),
        .i_funct3(i_funct3), .i_res_src(i_res_src), .i_reg_write(i_reg_write),
        .i_rd(i_rd), .i_store(i_store), .i_to_trap(i_to_trap),
        .i_reg_data2(i_reg_data2), .i_inst_jal_jalr(i_inst_jal_jalr),
        .i_inst_branch(i_inst_branch), .i_branch_pred(i_branch_pred),
        .i_pc(i_pc), .i_pc_next(i_pc_next), .i_pc_target(i_pc_target),
        .o_busy(o_busy), .o_result(o_result), .o_store_data(o_store_data),
        .o_rd(o_rd), .o_reg_write(o_reg_write), .o_store(o_store),
        .o_to_trap(o_to_trap), .o_res_src(o_res_src), .o_funct3(o_funct3),
        .o_pc_change(o_pc_change), .o_pc_new(o_pc_new)
    );

    // Free-running clock and an edge counter used for latency checks
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop in case something upstream of every bounded wait goes wrong
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exhausted");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drop every control input back to a harmless bubble
    task automatic idleInputs();
        i_res = RES_NONE; i_alu_ctrl = '0; i_funct3 = 3'b000;
        i_op1 = '0; i_op2 = '0; i_reg_write = 1'b0; i_rd = '0;
        i_inst_branch = 1'b0; i_inst_jal_jalr = 1'b0; i_branch_pred = 1'b0;
    endtask

    // Present one instruction, queue its expected output, hold it until taken
    task automatic applyStimulus(input string name, input alu_res_t res, input logic subSra,
                                 input logic isDiv, input logic [2:0] f3,
                                 input logic [31:0] op1, input logic [31:0] op2,
                                 input logic isBranch, input logic isJal, input logic pred,
                                 input logic [31:0] expResult, input logic expChange,
                                 input logic [31:0] expPcNew, input int latency, input int expBusy);
        expect_t e;
        int      busyCycles;
        int      waited;
        logic    canGo;
        tag = tag % 31 + 1;
        i_res = res; i_alu_ctrl.sub_sra = subSra; i_alu_ctrl.div = isDiv; i_funct3 = f3;
        i_op1 = op1; i_op2 = op2; i_inst_branch = isBranch; i_inst_jal_jalr = isJal;
        i_branch_pred = pred; i_reg_write = 1'b1; i_rd = 5'(tag);
        i_reg_data2 = 32'hA500_0000 | 32'(tag);
        e.name = name; e.result = expResult; e.pcChange = expChange; e.pcNew = expPcNew;
        e.storeData = i_reg_data2; e.rd = 5'(tag); e.dueCycle = cycle + latency;
        sbQueue.push_back(e);
        busyCycles = 0;
        waited = 0;
        canGo = 1'b0;
        while (!canGo && waited < 100) begin
            @(negedge clk);
            if (o_busy) busyCycles++;
            canGo = !o_busy && !i_stall;
            @(posedge clk); #1;
            waited++;
        end
        if (!canGo) begin
            missCount++;
            $display("[TB] FAIL %s timeout: still busy after %0d cycles", name, waited);
        end
        checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(expBusy));
        idleInputs();
    endtask

    // Monitor: a new register-writing output pops and checks one expectation
    initial begin : monitor
        logic [4:0] lastRd;
        expect_t    e;
        lastRd = '0;
        forever begin
            @(negedge clk);
            if (!o_reg_write) begin
                lastRd = '0;
            end else if (o_rd != lastRd) begin
                lastRd = o_rd;
                checkCount++;
                if (sbQueue.size() == 0) begin
                    missCount++;
                    $display("[TB] FAIL unexpected output: rd %0d result %h, nothing queued", o_rd, o_result);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput({e.name, " rd"}, 32'(o_rd), 32'(e.rd));
                    checkOutput({e.name, " result"}, o_result, e.result);
                    checkOutput({e.name, " pc_change"}, 32'(o_pc_change), 32'(e.pcChange));
                    if (e.pcChange) checkOutput({e.name, " pc_new"}, o_pc_new, e.pcNew);
                    checkOutput({e.name, " store_data"}, o_store_data, e.storeData);
                    checkOutput({e.name, " cycle"}, 32'(cycle), 32'(e.dueCycle));
                end
            end
        end
    end

    initial begin : stimulus
        i_reset = 1'b1; i_flush = 1'b0; i_stall = 1'b0;
        i_res_src = 2'b01; i_store = 1'b0; i_to_trap = 1'b0; i_reg_data2 = '0;
        i_pc = PC_CUR; i_pc_next = PC_NEXT; i_pc_target = PC_TARGET;
        idleInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("[TB] checking reset state");
        checkOutput("reset result", o_result, 32'd0);
        checkOutput("reset reg_write", 32'(o_reg_write), 32'd0);
        checkOutput("reset pc_change", 32'(o_pc_change), 32'd0);
        checkOutput("reset busy", 32'(o_busy), 32'd0);
        @(posedge clk); #1;
        i_reset = 1'b0;

        applyStimulus("ADD wrap", RES_ARITH, 0, 0, F3_ADD, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 32'h8000_0000, 0, 0, 1, 0);
        applyStimulus("SUB", RES_ARITH, 1, 0, F3_ADD, 32'd5, 32'd7, 0, 0, 0, 32'hFFFF_FFFE, 0, 0, 1, 0);
        applyStimulus("SRA 31", RES_SHIFT, 1, 0, F3_SR, 32'h8000_0000, 32'd31, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0);
        applyStimulus("SRL 31", RES_SHIFT, 0, 0, F3_SR, 32'h8000_0000, 32'd31, 0, 0, 0, 32'h0000_0001, 0, 0, 1, 0);
        applyStimulus("SLL low5", RES_SHIFT, 0, 0, F3_SLL, 32'd1, 32'd36, 0, 0, 0, 32'h0000_0010, 0, 0, 1, 0);
        applyStimulus("XOR", RES_LOGIC, 0, 0, F3_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 0, 32'h0FF0_0FF0, 0, 0, 1, 0);
        applyStimulus("AND", RES_LOGIC, 0, 0, F3_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 0, 32'hF000_F000, 0, 0, 1, 0);
        applyStimulus("SLT", RES_CMP, 0, 0, F3_SLT, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 32'd1, 0, 0, 1, 0);
        applyStimulus("SLTU", RES_CMP, 0, 0, F3_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 32'd0, 0, 0, 1, 0);
        applyStimulus("BLT mispredict", RES_NONE, 0, 0, F3_BLT, 32'hFFFF_FFFF, 32'd0, 1, 0, 0, 32'd0, 1, PC_TARGET, 1, 0);
        applyStimulus("BLT predicted", RES_NONE, 0, 0, F3_BLT, 32'hFFFF_FFFF, 32'd0, 1, 0, 1, 32'd0, 0, 0, 1, 0);
        applyStimulus("BGEU not taken", RES_NONE, 0, 0, F3_BGEU, 32'd1, 32'd2, 1, 0, 1, 32'd0, 1, PC_NEXT, 1, 0);
        applyStimulus("JAL link", RES_LINK, 0, 0, F3_ADD, 32'd0, 32'd0, 0, 1, 0, PC_NEXT, 1, PC_TARGET, 1, 0);

        applyStimulus("DIV -7/2", RES_DIV, 0, 1, F3_DIV, 32'd2, 32'hFFFF_FFF9, 0, 0, 0, 32'hFFFF_FFFD, 0, 0, 34, 33);
        applyStimulus("REM -7/2", RES_DIV, 0, 1, F3_REM, 32'd2, 32'hFFFF_FFF9, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 34, 33);
        applyStimulus("REMU 100/7", RES_DIV, 0, 1, F3_REMU, 32'd7, 32'd100, 0, 0, 0, 32'd2, 0, 0, 34, 33);
        applyStimulus("DIVU x/0", RES_DIV, 0, 1, F3_DIVU, 32'd0, 32'd100, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0);
        applyStimulus("REM x/0", RES_DIV, 0, 1, F3_REM, 32'd0, 32'd100, 0, 0, 0, 32'd100, 0, 0, 1, 0);
        applyStimulus("DIV overflow", RES_DIV, 0, 1, F3_DIV, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 32'h8000_0000, 0, 0, 1, 0);

        // Flush lands on E10 of a divide; the divide is squashed with it
        $display("[TB] flush mid-divide");
        i_res = RES_DIV; i_alu_ctrl.div = 1'b1; i_funct3 = F3_DIV;
        i_op1 = 32'd2; i_op2 = 32'hFFFF_FFF9; i_reg_write = 1'b1; i_rd = 5'd0;
        repeat (10) @(posedge clk);
        #1;
        idleInputs();
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        @(negedge clk);
        checkOutput("flush result", o_result, 32'd0);
        checkOutput("flush reg_write", 32'(o_reg_write), 32'd0);
        checkOutput("flush busy", 32'(o_busy), 32'd0);
        @(posedge clk); #1;
        applyStimulus("ADD after flush", RES_ARITH, 0, 0, F3_ADD, 32'd3, 32'd4, 0, 0, 0, 32'd7, 0, 0, 1, 0);

        // Reset lands mid-RUN of a divide
        $display("[TB] reset mid-divide");
        i_res = RES_DIV; i_alu_ctrl.div = 1'b1; i_funct3 = F3_DIV;
        i_op1 = 32'd2; i_op2 = 32'hFFFF_FFF9; i_reg_write = 1'b1; i_rd = 5'd0;
        repeat (5) @(posedge clk);
        #1;
        idleInputs();
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        checkOutput("reset-run result", o_result, 32'd0);
        checkOutput("reset-run reg_write", 32'(o_reg_write), 32'd0);
        checkOutput("reset-run store", 32'(o_store), 32'd0);
        checkOutput("reset-run to_trap", 32'(o_to_trap), 32'd0);
        checkOutput("reset-run pc_change", 32'(o_pc_change), 32'd0);
        checkOutput("reset-run busy", 32'(o_busy), 32'd0);
        @(posedge clk); #1;

        // Stall held across E20..E39: the finished quotient waits for E40
        $display("[TB] stall across divide completion");
        fork
            applyStimulus("DIV 100/-7 stalled", RES_DIV, 0, 1, F3_DIV, 32'hFFFF_FFF9, 32'd100, 0, 0, 0, 32'hFFFF_FFF2, 0, 0, 41, 33);
            begin
                repeat (20) @(posedge clk);
                #1 i_stall = 1'b1;
                repeat (20) @(posedge clk);
                #1 i_stall = 1'b0;
            end
        join

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
        $finish;
    end

endmodule
